// File: rtl/sensor_ar_multi.sv
// sensor_ar_multi: multi-channel synchronising debouncer for sensor/button inputs with
// symmetric press/release filtering, optional sample tick and press/release/long-hold pulses.
module sensor_ar_multi #(
    parameter int N_CH        = 4,
    parameter int COUNT_BOT   = 50000,
    parameter int SYNC_STAGES = 2,
    parameter bit IDLE_LEVEL  = 1'b1,
    parameter int HOLD_COUNT  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic [N_CH-1:0] sensor_in,
    output logic [N_CH-1:0] sensor_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] hold_flag,
    output logic [N_CH-1:0] hold_pulse
);
    localparam int CW  = $clog2(COUNT_BOT + 1);
    localparam int CW1 = CW + 1;
    localparam int HW  = HOLD_COUNT > 0 ? $clog2(HOLD_COUNT + 1) : 1;
    localparam logic [CW1-1:0] CB = CW1'(COUNT_BOT);
    localparam logic [HW-1:0]  HC = HW'(HOLD_COUNT);
    localparam bit HOLD_EN = HOLD_COUNT > 0;

    typedef enum logic [1:0] {REST, ARM, ACTIVE, DISARM} state_t;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        state_t                 r_state;
        logic [CW-1:0]          r_cnt;
        logic [HW-1:0]          r_hcnt;
        logic                   r_out, r_press, r_release, r_hflag, r_hpulse;
        logic                   w_idle, w_done;
        logic [CW1-1:0]         w_next;
        logic [HW-1:0]          w_hnext;

        assign w_idle  = r_sync[SYNC_STAGES-1] == IDLE_LEVEL;
        assign w_next  = {1'b0, r_cnt} + CW1'(tick);
        assign w_done  = w_next >= CB;
        // hold counter saturates at HOLD_COUNT so it can never wrap
        assign w_hnext = (tick && r_hcnt != HC) ? r_hcnt + HW'(1) : r_hcnt;

        assign sensor_out[g]    = r_out;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
        assign hold_flag[g]     = r_hflag;
        assign hold_pulse[g]    = r_hpulse;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync    <= {SYNC_STAGES{IDLE_LEVEL}};
                r_state   <= REST;
                r_cnt     <= '0;
                r_hcnt    <= '0;
                r_out     <= IDLE_LEVEL;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_hflag   <= 1'b0;
                r_hpulse  <= 1'b0;
            end else begin
                r_sync    <= {r_sync[SYNC_STAGES-2:0], sensor_in[g]};
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_hpulse  <= 1'b0;
                case (r_state)
                    REST: begin
                        if (!w_idle) begin
                            r_state <= ARM;
                            r_cnt   <= CW'(tick);
                        end
                    end
                    ARM: begin
                        if (w_idle) begin
                            r_state <= REST;
                            r_cnt   <= '0;
                        end else if (w_done) begin
                            r_state <= ACTIVE;
                            r_cnt   <= '0;
                            r_out   <= ~IDLE_LEVEL;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt <= w_next[CW-1:0];
                        end
                    end
                    ACTIVE: begin
                        if (HOLD_EN) begin
                            r_hcnt <= w_hnext;
                            if (w_hnext == HC && r_hcnt != HC) begin
                                r_hflag  <= 1'b1;
                                r_hpulse <= 1'b1;
                            end
                        end
                        if (w_idle) begin
                            r_state <= DISARM;
                            r_cnt   <= CW'(tick);
                        end
                    end
                    DISARM: begin
                        if (!w_idle) begin
                            r_state <= ACTIVE;
                            r_cnt   <= '0;
                        end else if (w_done) begin
                            r_state   <= REST;
                            r_cnt     <= '0;
                            r_out     <= IDLE_LEVEL;
                            r_release <= 1'b1;
                            r_hflag   <= 1'b0;
                            r_hcnt    <= '0;
                        end else begin
                            r_cnt <= w_next[CW-1:0];
                        end
                    end
                    default: r_state <= REST;
                endcase
            end
        end
    end
endmodule
